input_conditioner: RTL and testbench

- Input-side counterpart to the seven-segment display path: conditions raw board switches and push-keys before any logic consumes them.
- Per input: synchronises to clk, debounces, and emits a clean level plus single-cycle edge pulses.
- Downstream logic (operand latch, add/sub select) uses key_press as a clk-domain enable and never clocks a register directly from a key pin.

---
 rtl/input_conditioner_pkg.sv | 19 +
 rtl/input_conditioner_if.sv | 27 ++
 rtl/input_conditioner_debounce.sv | 51 +++++
 rtl/input_conditioner.sv | 108 ++++++++++
 tb/tb_input_conditioner.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner.
//   DEBOUNCE_CYCLES_DEF : default debounce length (5 ms at 50 MHz)
//   REPEAT_DELAY_DEF    : default hold time before auto-repeat starts
//   REPEAT_RATE_DEF     : default spacing of auto-repeat pulses
//   KEY_PRESSED_LEVEL   : internal level meaning "key pressed"
//   cnt_width()         : counter width for a given cycle count
package input_cond_pkg;

    localparam int   DEBOUNCE_CYCLES_DEF = 250000;
    localparam int   REPEAT_DELAY_DEF    = 25000000;
    localparam int   REPEAT_RATE_DEF     = 5000000;
    localparam logic KEY_PRESSED_LEVEL   = 1'b1;

    // Width of a counter that must hold values 0 .. cycles-1; never below 1.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Board-input bundle for the input conditioner.
//   key_raw/sw_raw          : raw asynchronous pins (driven by the board side)
//   key_level/press/release : debounced key state and edge pulses
//   sw_stable/sw_changed    : debounced switches and change pulse
// Modports: master = board/consumer side, slave = conditioner side.
interface input_conditioner_if #(
    parameter int N_KEYS = 4,
    parameter int N_SW   = 8
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_SW-1:0]   sw_raw;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_SW-1:0]   sw_stable;
    logic              sw_changed;

    modport master (
        output key_raw, sw_raw,
        input  key_level, key_press, key_release, sw_stable, sw_changed
    );

    modport slave (
        input  key_raw, sw_raw,
        output key_level, key_press, key_release, sw_stable, sw_changed
    );
endinterface

// File: rtl/input_conditioner_debounce.sv
// debounce_bit: one input bit through a 2-flop synchroniser, a stability
// counter and a stable flop, with registered rise/fall pulses.
//   clk, rst : clock, synchronous active-high reset
//   din      : raw asynchronous input bit
//   level    : debounced level
//   rise     : 1-cycle pulse when level goes 0 -> 1
//   fall     : 1-cycle pulse when level goes 1 -> 0
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync[1] == level) begin
                // any return to the stable value restarts the count
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // held different for DEBOUNCE_CYCLES cycles: accept it
                level <= sync[1];
                cnt   <= '0;
                rise  <= sync[1];
                fall  <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces push-keys and slide
// switches; produces clean levels and single-cycle edge pulses in clk domain.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : input_conditioner_if.slave (raw pins in, conditioned outputs out)
// Optional build macro INPUT_CONDITIONER_AUTOREPEAT_EN adds a key
// auto-repeat timer (REPEAT_DELAY / REPEAT_RATE) on the lowest held key.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int KEY_ACTIVE_LOW  = 1
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF
  , parameter int REPEAT_RATE     = REPEAT_RATE_DEF
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input_conditioner_if.slave  bus
);
    localparam logic PIN_PRESSED = (KEY_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    logic [N_KEYS-1:0] key_in, key_lvl, key_rise, key_fall;
    logic [N_SW-1:0]   sw_lvl, sw_rise, sw_fall;

    // Polarity is normalised before the synchroniser so that the reset
    // value of the sync flops (0) already means "released".
    always_comb begin
        key_in = '0;
        for (int i = 0; i < N_KEYS; i++)
            key_in[i] = (bus.key_raw[i] == PIN_PRESSED) ? KEY_PRESSED_LEVEL : ~KEY_PRESSED_LEVEL;
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .rst(rst), .din(key_in[i]),
            .level(key_lvl[i]), .rise(key_rise[i]), .fall(key_fall[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .rst(rst), .din(bus.sw_raw[i]),
            .level(sw_lvl[i]), .rise(sw_rise[i]), .fall(sw_fall[i])
        );
    end

    assign bus.key_level   = key_lvl;
    assign bus.key_release = key_fall;
    assign bus.sw_stable   = sw_lvl;
    assign bus.sw_changed  = |(sw_rise | sw_fall);

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = cnt_width(RMAX + 1);
    localparam int KW   = cnt_width(N_KEYS);

    logic              held, rep_active, rep_in_rate, rep_fire;
    logic [KW-1:0]     low_key, rep_key;
    logic [RW-1:0]     rep_cnt, rep_limit;
    logic [N_KEYS-1:0] key_rep;

    // rep_cnt = cycles the tracked key has been the lowest held key;
    // a repeat fires when it reaches the delay, then every REPEAT_RATE.
    always_comb begin
        held    = |key_lvl;
        low_key = '0;
        for (int i = N_KEYS - 1; i >= 0; i--)
            if (key_lvl[i]) low_key = KW'(i);
        rep_limit = rep_in_rate ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
        rep_fire  = rep_active && held && (low_key == rep_key) && (rep_cnt == rep_limit);
        key_rep   = '0;
        for (int i = 0; i < N_KEYS; i++)
            key_rep[i] = rep_fire && (rep_key == KW'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_active  <= 1'b0;
            rep_in_rate <= 1'b0;
            rep_key     <= '0;
            rep_cnt     <= '0;
        end else if (!held) begin
            rep_active  <= 1'b0;
            rep_in_rate <= 1'b0;
            rep_cnt     <= '0;
        end else if (!rep_active || low_key != rep_key) begin
            // new lowest held key: restart timing from its first held cycle
            rep_active  <= 1'b1;
            rep_key     <= low_key;
            rep_in_rate <= 1'b0;
            rep_cnt     <= RW'(1);
        end else if (rep_fire) begin
            rep_in_rate <= 1'b1;
            rep_cnt     <= RW'(1);
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    assign bus.key_press = key_rise | key_rep;
`else
    assign bus.key_press = key_rise;
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (DEBOUNCE_CYCLES=4, active-low
// keys). A behavioural model tracks how long each delayed input has differed
// from its accepted level; directed scenarios plus random stimulus.
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int NK  = 4;
    localparam int NS  = 8;
    localparam int DB  = 4;
    localparam int KAL = 1;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    localparam int RD = 10;
    localparam int RR = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    input_conditioner_if #(.N_KEYS(NK), .N_SW(NS)) bus ();

    input_conditioner #(
        .N_KEYS(NK), .N_SW(NS), .DEBOUNCE_CYCLES(DB), .KEY_ACTIVE_LOW(KAL)
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
      , .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
`endif
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Inputs reach the debouncer two clocks after being sampled.
    logic [NK-1:0] kd1 = '0, kd2 = '0;
    logic [NS-1:0] sd1 = '0, sd2 = '0;
    int            krun[NK];
    int            srun[NS];
    logic [NK-1:0] m_klvl = '0, m_kpress = '0, m_krel = '0;
    logic [NS-1:0] m_sw = '0;
    logic          m_swch = 1'b0;
    int            cyc = 0;
    int            rep_low = -1;
    int            rep_start = 0;

    task automatic model_edge();
        logic [NK-1:0] kin, kv;
        logic [NS-1:0] sv;
        int low;
        cyc++;
        kin = (KAL != 0) ? ~bus.key_raw : bus.key_raw;
        m_kpress = '0;
        m_krel   = '0;
        m_swch   = 1'b0;
        if (rst) begin
            kd1 = '0; kd2 = '0; sd1 = '0; sd2 = '0;
            m_klvl = '0; m_sw = '0;
            for (int i = 0; i < NK; i++) krun[i] = 0;
            for (int i = 0; i < NS; i++) srun[i] = 0;
            rep_low = -1;
            return;
        end
        kv = kd2; kd2 = kd1; kd1 = kin;
        sv = sd2; sd2 = sd1; sd1 = bus.sw_raw;
        for (int i = 0; i < NK; i++) begin
            krun[i] = (kv[i] != m_klvl[i]) ? krun[i] + 1 : 0;
            if (krun[i] == DB) begin
                krun[i] = 0;
                m_klvl[i] = kv[i];
                if (kv[i]) m_kpress[i] = 1'b1; else m_krel[i] = 1'b1;
            end
        end
        for (int i = 0; i < NS; i++) begin
            srun[i] = (sv[i] != m_sw[i]) ? srun[i] + 1 : 0;
            if (srun[i] == DB) begin
                srun[i] = 0;
                m_sw[i] = sv[i];
                m_swch  = 1'b1;
            end
        end
        low = -1;
        for (int i = NK - 1; i >= 0; i--) if (m_klvl[i]) low = i;
        if (low != rep_low) begin
            rep_low   = low;
            rep_start = cyc;
        end
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
        if (low >= 0) begin
            int e;
            e = cyc - rep_start;
            if (e == RD || (e > RD && (e - RD) % RR == 0)) m_kpress[low] = 1'b1;
        end
`endif
    endtask

    // One clock: model sees the same sampled inputs as the DUT, outputs
    // compared 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("key_level",   bus.key_level,   m_klvl);
        chk("key_press",   bus.key_press,   m_kpress);
        chk("key_release", bus.key_release, m_krel);
        chk("sw_stable",   bus.sw_stable,   m_sw);
        chk("sw_changed",  bus.sw_changed,  m_swch);
    endtask

    initial begin
        int seen, npulse, nbad, exp_press;
        logic [NK-1:0] val;

        rst = 1'b1;
        bus.key_raw = 4'b1111;
        bus.sw_raw  = 8'h00;
        repeat (3) tick();
        chk("rst_key_level", bus.key_level, 0);
        chk("rst_sw_stable", bus.sw_stable, 0);
        rst = 1'b0;
        repeat (3) tick();

        // clean press of key 0
        bus.key_raw = 4'b1110;
        seen = -1; nbad = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (bus.key_press[0] && seen < 0) seen = n;
            if (bus.key_release != 0) nbad++;
        end
        chk("press_latency", seen, 6);
        chk("press_no_release", nbad, 0);
        chk("press_level", bus.key_level, 4'b0001);

        // bounce on key 1 shorter than the debounce window
        bus.key_raw = 4'b1100;
        repeat (3) tick();
        bus.key_raw = 4'b1110;
        nbad = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (bus.key_press[1] || bus.key_release[1] || bus.key_level[1]) nbad++;
        end
        chk("bounce_rejected", nbad, 0);

        // switches change together
        bus.sw_raw = 8'hA5;
        seen = -1; npulse = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (bus.sw_changed) begin
                npulse++;
                if (seen < 0) seen = n;
            end
        end
        chk("sw_latency", seen, 6);
        chk("sw_pulse_count", npulse, 1);
        chk("sw_value", bus.sw_stable, 8'hA5);

        // release all, then keys 0 and 3 together
        bus.key_raw = 4'b1111;
        repeat (10) tick();
        bus.key_raw = 4'b0110;
        val = '0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (bus.key_press != 0) val = bus.key_press;
        end
        chk("simul_press", val, 4'b1001);
        bus.key_raw = 4'b1111;
        seen = -1; val = '0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (bus.key_release != 0 && seen < 0) begin
                seen = n;
                val  = bus.key_release;
            end
        end
        chk("simul_release_latency", seen, 6);
        chk("simul_release", val, 4'b1001);

        // reset in the middle of a debounce count
        bus.key_raw = 4'b1011;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = -1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (bus.key_press != 0 && seen < 0) seen = n;
        end
        chk("rst_mid_latency", seen, 6);
        bus.key_raw = 4'b1111;
        repeat (10) tick();

        // long hold of key 0: one press, plus repeats when enabled
        bus.key_raw = 4'b1110;
        npulse = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (bus.key_press[0]) npulse++;
        end
        exp_press = 1;
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
        for (int e = RD; 6 + e <= 40; e += RR) exp_press++;
`endif
        chk("hold_press_count", npulse, exp_press);
        bus.key_raw = 4'b1111;
        npulse = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n > 6 && bus.key_press != 0) npulse++;
        end
        chk("no_press_after_release", npulse, 0);

        // random stimulus against the model
        for (int c = 0; c < 1500; c++) begin
            logic [NK-1:0] km;
            logic [NS-1:0] sm;
            km = '0;
            sm = '0;
            for (int i = 0; i < NK; i++) km[i] = ($urandom_range(5) == 0);
            for (int i = 0; i < NS; i++) sm[i] = ($urandom_range(9) == 0);
            bus.key_raw = bus.key_raw ^ km;
            bus.sw_raw  = bus.sw_raw ^ sm;
            rst = ($urandom_range(199) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
